// File: rtl/tt_um_mac_accelerator_on_sachin_sharma.sv
// Tiny Tapeout multiply-accumulate block: 4x4 product added into an 8-bit
// accumulator with optional two's-complement operands and saturation.
module tt_um_mac_accelerator_on_sachin_sharma (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [7:0] uio_in,
   output logic [7:0] C,
   output logic [7:0] uio_ou,
   output logic [7:0] uio_oe
);

   logic       mac_en, clr, sat, sgn;
   logic [7:0] prod;
   logic [9:0] sum;
   logic       overflow;
   logic [7:0] sat_val;

   logic [7:0] acc_q, acc_d;
   logic       valid_q, valid_d;
   logic       ovf_q, ovf_d;
   logic       sticky_q, sticky_d;

   logic       unused_uio;

   assign mac_en     = uio_in[0];
   assign clr        = uio_in[1];
   assign sat        = uio_in[2];
   assign sgn        = uio_in[3];
   assign unused_uio = &{1'b0, uio_in[7:4]};

   // Signed mode sign-extends operands to 8 bits, so the product is already
   // sign-extended; the 10-bit sum then extends by the top bit of each term.
   always_comb begin
      if (sgn) begin
         prod     = $signed({{4{a[3]}}, a}) * $signed({{4{b[3]}}, b});
         sum      = {{2{acc_q[7]}}, acc_q} + {{2{prod[7]}}, prod};
         overflow = (sum[9:7] != 3'b000) && (sum[9:7] != 3'b111);
         sat_val  = sum[9] ? 8'h80 : 8'h7F;
      end else begin
         prod     = {4'd0, a} * {4'd0, b};
         sum      = {2'b00, acc_q} + {2'b00, prod};
         overflow = |sum[9:8];
         sat_val  = 8'hFF;
      end
   end

   // NOTE: every next-state signal gets a default first so no latch is inferred.
   always_comb begin
      acc_d    = acc_q;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      sticky_d = sticky_q;
      if (clr) begin
         acc_d    = mac_en ? prod : 8'h00;
         valid_d  = mac_en;
         sticky_d = 1'b0;
      end else if (mac_en) begin
         acc_d    = (overflow && sat) ? sat_val : sum[7:0];
         valid_d  = 1'b1;
         ovf_d    = overflow;
         sticky_d = sticky_q | overflow;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q    <= 8'h00;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else if (ena) begin
         acc_q    <= acc_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         sticky_q <= sticky_d;
      end
   end

   assign C      = acc_q;
   assign uio_ou = {(acc_q == 8'h00), sticky_q, ovf_q, valid_q, 4'h0};
   assign uio_oe = 8'hF0;

endmodule

// File: tb/tb_tt_um_mac_accelerator_on_sachin_sharma.sv
// Directed bench for the MAC block: hand-computed accumulator and status values.
module tb_tt_um_mac_accelerator_on_sachin_sharma;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [3:0] a, b;
   logic [7:0] uio_in;
   logic [7:0] C, uio_ou, uio_oe;

   int total = 0;
   int bad   = 0;

   tt_um_mac_accelerator_on_sachin_sharma dut (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .a      (a),
      .b      (b),
      .uio_in (uio_in),
      .C      (C),
      .uio_ou (uio_ou),
      .uio_oe (uio_oe)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ctl bits: {sgn, sat, clr, mac_en}
   task automatic drive(input logic [3:0] ctl, input logic [3:0] aa, input logic [3:0] bb);
      uio_in = {4'h0, ctl};
      a      = aa;
      b      = bb;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ena    = 1'($urandom);
         a      = 4'($urandom);
         b      = 4'($urandom);
         uio_in = 8'($urandom);
         step();
      end
      total++;
      if (C !== 8'h00) begin bad++; $display("FAIL reset_C got=%h exp=00", C); end
      total++;
      if (uio_ou !== 8'h80) begin bad++; $display("FAIL reset_status got=%h exp=80", uio_ou); end
      total++;
      if (uio_oe !== 8'hF0) begin bad++; $display("FAIL reset_oe got=%h exp=F0", uio_oe); end
      rst = 1'b1;
      ena = 1'b1;
      drive(4'b0000, 4'd0, 4'd0);
   endtask

   task automatic test_unsigned(input logic s);
      logic [7:0] fin;
      logic [7:0] fin_st;
      fin    = s ? 8'hFF : 8'h06;
      fin_st = s ? 8'h60 : 8'h60;
      drive({1'b0, s, 2'b11}, 4'd15, 4'd15);
      total++;
      if (C !== 8'hE1 || uio_ou !== 8'h10) begin
         bad++; $display("FAIL uns_first sat=%0d got C=%h st=%h exp C=E1 st=10", s, C, uio_ou);
      end
      drive({1'b0, s, 2'b01}, 4'd3, 4'd4);
      total++;
      if (C !== 8'hED || uio_ou !== 8'h10) begin
         bad++; $display("FAIL uns_second sat=%0d got C=%h st=%h exp C=ED st=10", s, C, uio_ou);
      end
      drive({1'b0, s, 2'b01}, 4'd5, 4'd5);
      total++;
      if (C !== fin || uio_ou !== (fin_st | 8'h10)) begin
         bad++; $display("FAIL uns_ovf sat=%0d got C=%h st=%h exp C=%h st=%h", s, C, uio_ou, fin, fin_st | 8'h10);
      end
      drive({1'b0, s, 2'b00}, 4'd5, 4'd5);
      total++;
      if (C !== fin || uio_ou !== 8'h40) begin
         bad++; $display("FAIL uns_idle sat=%0d got C=%h st=%h exp C=%h st=40", s, C, uio_ou, fin);
      end
   endtask

   task automatic test_signed();
      drive(4'b1011, 4'd8, 4'd8);
      total++;
      if (C !== 8'h40 || uio_ou !== 8'h10) begin
         bad++; $display("FAIL sgn_prod got C=%h st=%h exp C=40 st=10", C, uio_ou);
      end
      drive(4'b1101, 4'd8, 4'd8);
      total++;
      if (C !== 8'h7F || uio_ou !== 8'h70) begin
         bad++; $display("FAIL sgn_sat got C=%h st=%h exp C=7F st=70", C, uio_ou);
      end
      drive(4'b1011, 4'd8, 4'd8);
      drive(4'b1001, 4'd8, 4'd8);
      total++;
      if (C !== 8'h80 || uio_ou !== 8'h70) begin
         bad++; $display("FAIL sgn_wrap got C=%h st=%h exp C=80 st=70", C, uio_ou);
      end
      drive(4'b1011, 4'd8, 4'd7);
      total++;
      if (C !== 8'hC8 || uio_ou !== 8'h10) begin
         bad++; $display("FAIL sgn_neg got C=%h st=%h exp C=C8 st=10", C, uio_ou);
      end
      // -56 + -56 = -112 stays in range; then -112 + -56 saturates low to -128
      drive(4'b1101, 4'd8, 4'd7);
      drive(4'b1101, 4'd8, 4'd7);
      total++;
      if (C !== 8'h80 || uio_ou !== 8'h70) begin
         bad++; $display("FAIL sgn_sat_low got C=%h st=%h exp C=80 st=70", C, uio_ou);
      end
   endtask

   task automatic test_enable();
      drive(4'b0011, 4'd4, 4'd4);
      total++;
      if (C !== 8'h10 || uio_ou !== 8'h10) begin
         bad++; $display("FAIL ena_setup got C=%h st=%h exp C=10 st=10", C, uio_ou);
      end
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(4'b0001, 4'd1, 4'd1);
         total++;
         if (C !== 8'h10 || uio_ou !== 8'h10) begin
            bad++; $display("FAIL ena_hold cyc=%0d got C=%h st=%h exp C=10 st=10", i, C, uio_ou);
         end
      end
      ena = 1'b1;
      drive(4'b0001, 4'd1, 4'd1);
      total++;
      if (C !== 8'h11 || uio_ou !== 8'h10) begin
         bad++; $display("FAIL ena_resume got C=%h st=%h exp C=11 st=10", C, uio_ou);
      end
   endtask

   task automatic test_clear();
      drive(4'b0011, 4'd15, 4'd15);
      drive(4'b0001, 4'd5, 4'd8);
      total++;
      if (C !== 8'h09 || uio_ou !== 8'h70) begin
         bad++; $display("FAIL clr_setup got C=%h st=%h exp C=09 st=70", C, uio_ou);
      end
      drive(4'b0010, 4'd3, 4'd3);
      total++;
      if (C !== 8'h00 || uio_ou !== 8'h80) begin
         bad++; $display("FAIL clr_only got C=%h st=%h exp C=00 st=80", C, uio_ou);
      end
   endtask

   task automatic test_mid_reset();
      drive(4'b0011, 4'd15, 4'd15);
      drive(4'b0001, 4'd15, 4'd15);
      ena = 1'b0;
      rst = 1'b0;
      drive(4'b0001, 4'd7, 4'd7);
      total++;
      if (C !== 8'h00 || uio_ou !== 8'h80) begin
         bad++; $display("FAIL mid_reset got C=%h st=%h exp C=00 st=80", C, uio_ou);
      end
      rst = 1'b1;
      ena = 1'b1;
   endtask

   task automatic test_back_to_back();
      drive(4'b0011, 4'd1, 4'd2);
      for (int i = 1; i <= 5; i++) begin
         drive(4'b0001, 4'd1, 4'd2);
      end
      total++;
      if (C !== 8'h0C || uio_ou !== 8'h10) begin
         bad++; $display("FAIL b2b got C=%h st=%h exp C=0C st=10", C, uio_ou);
      end
   endtask

   initial begin
      rst    = 1'b0;
      ena    = 1'b0;
      a      = 4'h0;
      b      = 4'h0;
      uio_in = 8'h00;
      test_reset();
      test_unsigned(1'b0);
      test_clear();
      test_unsigned(1'b1);
      test_signed();
      test_enable();
      test_mid_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
